// File: rtl/arm_defs_pkg.sv
// Shared definitions for the memory arbiter of the pipelined ARM core:
// the arbiter FSM state encoding and the default address/data widths.
package arm_defs;

  localparam int ARB_AW = 32;
  localparam int ARB_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_ibuf.sv
// One-entry instruction buffer for the memory arbiter (used only when
// ARB_IBUF_EN is defined). Holds the last fetched word with its full
// address tag. A store to the same word clears the entry.
module arb_ibuf
  import arm_defs::*;
#(
  parameter int AW = ARB_AW,
  parameter int DW = ARB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] lookup_addr,
  output logic          hit,
  output logic [DW-1:0] hit_data,
  input  logic          fill,
  input  logic [AW-1:0] fill_addr,
  input  logic [DW-1:0] fill_data,
  input  logic          inval,
  input  logic [AW-1:0] inval_addr
);

  logic          valid_q;
  logic [AW-1:0] tag_q;
  logic [DW-1:0] data_q;

  assign hit      = valid_q && (tag_q == lookup_addr);
  assign hit_data = data_q;

  // Valid bit: set on refill, cleared by reset or a store to the cached word.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else if (fill) begin
      valid_q <= 1'b1;
    end else if (inval && (inval_addr[AW-1:2] == tag_q[AW-1:2])) begin
      valid_q <= 1'b0;
    end
  end

  // Tag and data only need capturing on refill; the valid bit guards them.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q  <= fill_addr;
      data_q <= fill_data;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the single-port unified instruction/data memory. Each pipeline
// advance ("bundle") serves the M-stage data access first, then the F-stage
// fetch, holding StallArb until both are done. A bundle starts in the same
// cycle it is requested, so a zero-wait fetch-only bundle costs no stall.
// Fetches hit by a branch redirect still complete on the bus but are
// discarded and reissued with the new PCF. The fetch address is held while a
// fetch is outstanding so the bus stays stable even if PCF moves.
// Optional feature: define ARB_IBUF_EN to add a one-entry instruction buffer.
module mem_arbiter
  import arm_defs::*;
#(
  parameter int AW = ARB_AW,
  parameter int DW = ARB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] PCF,
  input  logic          IReqF,
  input  logic          RedirectF,
  output logic [DW-1:0] InstrF,
  output logic          IValidF,
  input  logic          DReqM,
  input  logic          MemWriteM,
  input  logic [AW-1:0] ALUResultM,
  input  logic [DW-1:0] WriteDataM,
  output logic [DW-1:0] ReadDataM,
  output logic          StallArb,
  output logic          MemReq,
  output logic          MemWE,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWD,
  input  logic [DW-1:0] MemRD,
  input  logic          MemAck
);

  arb_state_e    state_q;
  arb_state_e    cur;
  arb_state_e    nxt;
  logic          drop_q;
  logic          fetch_busy_q;
  logic [AW-1:0] fetch_addr_q;
  logic [AW-1:0] fetch_addr;
  logic          fetch_done;
  logic          discard;
  logic [DW-1:0] fetch_data;
  logic          load_en;
  logic          fill_en;
  logic          inval_en;
  logic          ibuf_hit;
  logic [DW-1:0] ibuf_data;

  // Fetch address: PCF when an access starts, the captured address while outstanding.
  assign fetch_addr = fetch_busy_q ? fetch_addr_q : PCF;

`ifdef ARB_IBUF_EN
  arb_ibuf #(
    .AW (AW),
    .DW (DW)
  ) u_ibuf (
    .clk         (clk),
    .reset       (reset),
    .lookup_addr (PCF),
    .hit         (ibuf_hit),
    .hit_data    (ibuf_data),
    .fill        (fill_en),
    .fill_addr   (fetch_addr),
    .fill_data   (MemRD),
    .inval       (inval_en),
    .inval_addr  (ALUResultM)
  );
`else
  logic ibuf_unused;

  assign ibuf_hit    = 1'b0;
  assign ibuf_data   = '0;
  assign ibuf_unused = fill_en ^ inval_en;
`endif

  // Effective state: an idle arbiter starts a new bundle in the request cycle.
  always_comb begin
    cur = state_q;
    if (state_q == IDLE) begin
      if (DReqM) begin
        cur = DATA;
      end else if (IReqF) begin
        cur = FETCH;
      end
    end
  end

  // Next state, memory bus, stall and fetch result for the current cycle.
  always_comb begin
    nxt        = IDLE;
    MemReq     = 1'b0;
    MemWE      = 1'b0;
    MemAddr    = '0;
    MemWD      = '0;
    StallArb   = 1'b0;
    IValidF    = 1'b0;
    InstrF     = '0;
    load_en    = 1'b0;
    fill_en    = 1'b0;
    inval_en   = 1'b0;
    fetch_done = 1'b0;
    discard    = 1'b0;
    fetch_data = '0;
    unique case (cur)
      IDLE: begin
        nxt = IDLE;
      end
      DATA: begin
        MemReq  = 1'b1;
        MemWE   = MemWriteM;
        MemAddr = ALUResultM;
        MemWD   = WriteDataM;
        if (MemAck) begin
          load_en  = !MemWriteM;
          inval_en = MemWriteM;
          if (IReqF) begin
            nxt      = FETCH;
            StallArb = 1'b1;
          end else begin
            nxt = IDLE;
          end
        end else begin
          nxt      = DATA;
          StallArb = 1'b1;
        end
      end
      FETCH: begin
        discard = drop_q || RedirectF;
        if (!fetch_busy_q && ibuf_hit) begin
          fetch_done = 1'b1;
          fetch_data = ibuf_data;
        end else begin
          MemReq  = 1'b1;
          MemAddr = fetch_addr;
          if (MemAck) begin
            fetch_done = 1'b1;
            fetch_data = MemRD;
            fill_en    = 1'b1;
          end
        end
        if (fetch_done && !discard) begin
          IValidF = 1'b1;
          InstrF  = fetch_data;
          nxt     = IDLE;
        end else begin
          StallArb = 1'b1;
          nxt      = FETCH;
        end
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  // State, redirect-drop flag, outstanding-fetch address and load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      drop_q       <= 1'b0;
      fetch_busy_q <= 1'b0;
      fetch_addr_q <= '0;
      ReadDataM    <= '0;
    end else begin
      state_q      <= nxt;
      fetch_busy_q <= (cur == FETCH) && MemReq && !MemAck;
      if (cur == FETCH) begin
        fetch_addr_q <= fetch_addr;
        drop_q       <= fetch_done ? 1'b0 : (drop_q || RedirectF);
      end
      if (load_en) begin
        ReadDataM <= MemRD;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port unified instruction/data memory between the Fetch stage and the Memory stage of the pipelined ARM core. Serializes one data access and one instruction fetch per pipeline advance, with data first. Stalls the whole pipeline until both are served. Drops fetches invalidated by a branch redirect. Sits between the datapath, the hazard logic and the memory, and exposes a MemReq/MemAck handshake toward memory.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data/instruction width

Ports:
- clk  in  1  single clock; everything samples on rising edge
- reset  in  1  synchronous, active-high
- PCF  in  AW  fetch address
- IReqF  in  1  fetch requested this pipeline cycle
- RedirectF  in  1  branch taken (PCSrcW/BranchTakenE); current fetch is stale
- InstrF  out  DW  fetched instruction, valid while IValidF
- IValidF  out  1  instruction for PCF available
- DReqM  in  1  data access needed (MemWriteM | MemtoRegM)
- MemWriteM  in  1  1 = store, 0 = load
- ALUResultM  in  AW  data address
- WriteDataM  in  DW  store data
- ReadDataM  out  DW  load result, held until advance
- StallArb  out  1  freeze all pipeline registers (F/D/E/M/W)
- MemReq  out  1  memory access request
- MemWE  out  1  write enable, valid with MemReq
- MemAddr  out  AW  access address
- MemWD  out  DW  write data
- MemRD  in  DW  read data, valid with MemAck
- MemAck  in  1  access complete this cycle; may be same-cycle as MemReq

## Operation
- FSM states: IDLE, DATA, FETCH. A "bundle" is the work for one pipeline advance: the data access if DReqM, plus the fetch if IReqF.
- Each bundle starts in DATA if DReqM, else in FETCH if IReqF, else it stays in IDLE with StallArb=0.
- DATA drives MemAddr=ALUResultM, MemWE=MemWriteM and MemWD=WriteDataM.
  - On MemAck: latch MemRD into ReadDataM for loads and set dDone.
  - Then go to FETCH if IReqF; otherwise the bundle is complete.
- FETCH drives MemAddr=PCF and MemWE=0.
  - On MemAck: InstrF=MemRD, IValidF=1 and set iDone. The bundle is complete.
- Completion cycle: StallArb=0, pipeline advances, dDone/iDone clear, and the next bundle is evaluated the following cycle.
- StallArb=1 in every other cycle of a bundle. It is combinational from state and MemAck.
- MemReq, MemAddr, MemWE and MemWD stay stable until MemAck. An access is never cancelled mid-flight.
- RedirectF during FETCH:
  - The access still completes, but its result is discarded and IValidF stays 0.
  - A drop flag holds this until that MemAck.
  - The arbiter then re-enters FETCH with the new PCF.
- RedirectF in the same cycle as a fetch MemAck: the result is discarded.
- RedirectF during DATA: the data access completes normally.
- Inputs are sampled while StallArb=1. The datapath guarantees M-stage inputs are stable while stalled.

## Timing
- Reset values: state=IDLE, StallArb=0, MemReq=0, MemWE=0, MemAddr=0, MemWD=0, InstrF=0, IValidF=0, ReadDataM=0. dDone, iDone and the drop flag are cleared.
- Reset mid-access: MemReq drops in the cycle after reset is sampled, and the outstanding access is abandoned.
- Zero-wait memory (MemAck same cycle):
  - Fetch-only bundle: 1 cycle, no stall.
  - Data+fetch bundle: 2 cycles, 1 stall cycle.
- N-wait memory: fetch-only bundle takes N+1 cycles; data+fetch takes 2(N+1).
- IValidF is a single-cycle pulse. It is coincident with StallArb=0 unless a redirect drop is active.

## Configuration
- Macro ARB_IBUF_EN.
- Defined: a one-entry instruction buffer is added, holding a tag, data and a valid bit.
  - In FETCH with valid && tag==PCF: the fetch completes in the same cycle with no MemReq.
  - Every completed memory fetch refills the buffer.
  - A store with ALUResultM[AW-1:2]==tag[AW-1:2] clears the valid bit in its MemAck cycle.
  - Reset clears the valid bit.
- Undefined: no buffer; every fetch goes to memory.

## Structure
- Shared package/header arm_defs: state encodings (IDLE/DATA/FETCH) and AW/DW defaults.
- One sub-module, arb_ibuf (tag/data/valid, lookup, invalidate). It is instantiated only under ARB_IBUF_EN.

## Test plan
- Fetch-only, MemAck tied 1, PCF=0x0000_0010 → MemReq=1, MemAddr=0x10 in the same cycle; IValidF=1; StallArb=0.
- Load at 0x0000_0100 plus fetch at 0x14, zero-wait → cycle 1: MemAddr=0x100, StallArb=1, ReadDataM latched. Cycle 2: MemAddr=0x14, IValidF=1, StallArb=0.
- Store 0xDEADBEEF to 0x200 with MemAck delayed 2 cycles → MemReq/MemWE/MemAddr/MemWD held stable 3 cycles; StallArb=1 throughout; the fetch follows.
- RedirectF pulsed during a 2-wait fetch of 0x20, new PCF=0x80 → no IValidF for 0x20; the next MemAddr is 0x80 and IValidF=1 for it.
- Reset asserted mid-DATA → next cycle MemReq=0, StallArb=0, all outputs at reset values.
- ARB_IBUF_EN: fetch 0x30 twice → the second fetch has no MemReq. Then store to 0x30, then fetch 0x30 → MemReq=1 again.
